// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single external memory read port between the I-side and
// D-side cache refill controllers. One owner at a time; the grant is held for a full
// BURST_LEN-beat refill or until the owner drops its request.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin on ties (last-served pointer, D wins first tie)
//              undefined -> fixed priority, D-side wins every tie
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; sample i_req/d_req and pick the next owner
// OWN_I | I-side owns the port; mem_ack routed to i_ack
// OWN_D | D-side owns the port; mem_ack routed to d_ack
module mem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 2,   // 2**CNT_W must be >= BURST_LEN
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset,     // asynchronous, active-low
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ack,
  input  logic            d_req,
  input  logic [XLEN-1:0] d_addr,
  output logic            d_ack,
  output logic [XLEN-1:0] rd_data,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_data,
  output logic            grant_i,
  output logic            grant_d
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_I = 2'b01,
    OWN_D = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_i_q, grant_d_q;

`ifdef ARB_RR_EN
  // 1 = D-side was served last, 0 = I-side was served last
  logic             last_d_q, last_d_d;
`endif

  // Next-state: arbitration in IDLE, beat counting / release / abort while owned
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef ARB_RR_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef ARB_RR_EN
        if (i_req && d_req) begin
          state_d = last_d_q ? OWN_I : OWN_D;
        end else if (d_req) begin
          state_d = OWN_D;
        end else if (i_req) begin
          state_d = OWN_I;
        end
        if (state_d != IDLE) begin
          last_d_d = (state_d == OWN_D);
        end
`else
        if (d_req) begin
          state_d = OWN_D;
        end else if (i_req) begin
          state_d = OWN_I;
        end
`endif
      end
      OWN_I: begin
        if (!i_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (mem_ack) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      OWN_D: begin
        if (!d_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (mem_ack) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        // unused encoding recovers to IDLE
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM registers; grant flags are registered decodes of the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_i_q <= 1'b0;
      grant_d_q <= 1'b0;
`ifdef ARB_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_i_q <= (state_d == OWN_I);
      grant_d_q <= (state_d == OWN_D);
`ifdef ARB_RR_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  assign grant_i = grant_i_q;
  assign grant_d = grant_d_q;

  // Owner's request/address forwarded to memory; ack routed to owner only
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    if (grant_i_q) begin
      mem_req  = i_req;
      mem_addr = i_addr;
      i_ack    = mem_ack;
    end else if (grant_d_q) begin
      mem_req  = d_req;
      mem_addr = d_addr;
      d_ack    = mem_ack;
    end
  end

  assign rd_data = mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table plus a hand-written
// back-to-back burst sequence with both requesters held.
module tb_mem_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_req, d_req, mem_ack;
  logic [XLEN-1:0] i_addr, d_addr, mem_data;
  logic            i_ack, d_ack, mem_req, grant_i, grant_d;
  logic [XLEN-1:0] rd_data, mem_addr;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.BURST_LEN(4), .CNT_W(2), .XLEN(XLEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_ack    (d_ack),
    .rd_data  (rd_data),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .grant_i  (grant_i),
    .grant_d  (grant_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic        ack;
    logic        gi, gd, mreq;
    logic [31:0] maddr;
    logic        iack, dack;
  } vec_t;

  typedef logic [68:0] obs_t;   // {gi, gd, mreq, maddr, iack, dack, rd_data}

  vec_t       vecs[$];
  obs_t       sb_q[$];
  logic [1:0] own_q[$];

  function automatic vec_t mk(input string name, input logic rst,
                              input logic ireq, input logic [31:0] iaddr,
                              input logic dreq, input logic [31:0] daddr, input logic ack,
                              input logic gi, input logic gd, input logic mreq,
                              input logic [31:0] maddr, input logic iack, input logic dack);
    vec_t v;
    v.name = name; v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq;
    v.daddr = daddr; v.ack = ack; v.gi = gi; v.gd = gd; v.mreq = mreq;
    v.maddr = maddr; v.iack = iack; v.dack = dack;
    return v;
  endfunction

  // drive one vector just after the edge, check the same cycle on the falling edge
  task automatic apply(input vec_t v);
    obs_t got, exp;
    @(posedge clk);
    #1;
    reset    = v.rst;
    i_req    = v.ireq;
    i_addr   = v.iaddr;
    d_req    = v.dreq;
    d_addr   = v.daddr;
    mem_ack  = v.ack;
    mem_data = $urandom;
    sb_q.push_back({v.gi, v.gd, v.mreq, v.maddr, v.iack, v.dack, mem_data});
    @(negedge clk);
    got = {grant_i, grant_d, mem_req, mem_addr, i_ack, d_ack, rd_data};
    exp = sb_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got gi/gd/mreq=%b%b%b addr=%h iack/dack=%b%b rd=%h, exp gi/gd/mreq=%b%b%b addr=%h iack/dack=%b%b rd=%h",
               v.name, got[68], got[67], got[66], got[65:34], got[33], got[32], got[31:0],
               exp[68], exp[67], exp[66], exp[65:34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  exp_order [3];
    logic [1:0]  eo;
    logic [31:0] ea;
    int          n;

    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; mem_data = '0;
    repeat (2) @(posedge clk);

    //                 name        rst i  iaddr      d  daddr      ack  gi gd mr maddr      ia da
    vecs.push_back(mk("reset",     0, 1, 32'h100, 1, 32'h400, 1,   0, 0, 0, 32'h0,   0, 0));
    // single I-side burst, with one idle beat in the middle
    vecs.push_back(mk("t2_idle",   1, 1, 32'h100, 0, 32'h0,   0,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk("t2_b1",     1, 1, 32'h100, 0, 32'h0,   1,   1, 0, 1, 32'h100, 1, 0));
    vecs.push_back(mk("t2_wait",   1, 1, 32'h101, 0, 32'h0,   0,   1, 0, 1, 32'h101, 0, 0));
    vecs.push_back(mk("t2_b2",     1, 1, 32'h101, 0, 32'h0,   1,   1, 0, 1, 32'h101, 1, 0));
    vecs.push_back(mk("t2_b3",     1, 1, 32'h102, 0, 32'h0,   1,   1, 0, 1, 32'h102, 1, 0));
    vecs.push_back(mk("t2_b4",     1, 1, 32'h103, 0, 32'h0,   1,   1, 0, 1, 32'h103, 1, 0));
    vecs.push_back(mk("t2_rel",    1, 0, 32'h0,   0, 32'h0,   1,   0, 0, 0, 32'h0,   0, 0));
    // simultaneous requests from reset: D first, then I
    vecs.push_back(mk("t3_tie",    1, 1, 32'h300, 1, 32'h400, 0,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk("t3_d1",     1, 1, 32'h300, 1, 32'h400, 1,   0, 1, 1, 32'h400, 0, 1));
    vecs.push_back(mk("t3_d2",     1, 1, 32'h300, 1, 32'h401, 1,   0, 1, 1, 32'h401, 0, 1));
    vecs.push_back(mk("t3_d3",     1, 1, 32'h300, 1, 32'h402, 1,   0, 1, 1, 32'h402, 0, 1));
    vecs.push_back(mk("t3_d4",     1, 1, 32'h300, 1, 32'h403, 1,   0, 1, 1, 32'h403, 0, 1));
    vecs.push_back(mk("t3_gap",    1, 1, 32'h300, 0, 32'h0,   0,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk("t3_owni",   1, 1, 32'h300, 0, 32'h0,   0,   1, 0, 1, 32'h300, 0, 0));
    vecs.push_back(mk("t3_drop",   1, 0, 32'h300, 0, 32'h0,   0,   1, 0, 0, 32'h300, 0, 0));
    // I-side aborts after one beat (ack in the abort cycle still routed), D then needs 4 beats
    vecs.push_back(mk("t5_idle",   1, 1, 32'h500, 0, 32'h0,   0,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk("t5_i1",     1, 1, 32'h500, 1, 32'h600, 1,   1, 0, 1, 32'h500, 1, 0));
    vecs.push_back(mk("t5_abort",  1, 0, 32'h501, 1, 32'h600, 1,   1, 0, 0, 32'h501, 1, 0));
    vecs.push_back(mk("t5_gap",    1, 0, 32'h0,   1, 32'h600, 0,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk("t5_d1",     1, 0, 32'h0,   1, 32'h600, 1,   0, 1, 1, 32'h600, 0, 1));
    vecs.push_back(mk("t5_d2",     1, 0, 32'h0,   1, 32'h601, 1,   0, 1, 1, 32'h601, 0, 1));
    vecs.push_back(mk("t5_d3",     1, 0, 32'h0,   1, 32'h602, 1,   0, 1, 1, 32'h602, 0, 1));
    vecs.push_back(mk("t5_d4",     1, 0, 32'h0,   1, 32'h603, 1,   0, 1, 1, 32'h603, 0, 1));
    // D request raised mid I-burst is ignored until I-side completes
    vecs.push_back(mk("t6_idle",   1, 1, 32'h700, 0, 32'h0,   0,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk("t6_i1",     1, 1, 32'h700, 0, 32'h0,   1,   1, 0, 1, 32'h700, 1, 0));
    vecs.push_back(mk("t6_i2",     1, 1, 32'h701, 1, 32'h800, 1,   1, 0, 1, 32'h701, 1, 0));
    vecs.push_back(mk("t6_wait",   1, 1, 32'h702, 1, 32'h800, 0,   1, 0, 1, 32'h702, 0, 0));
    vecs.push_back(mk("t6_i3",     1, 1, 32'h702, 1, 32'h800, 1,   1, 0, 1, 32'h702, 1, 0));
    vecs.push_back(mk("t6_i4",     1, 1, 32'h703, 1, 32'h800, 1,   1, 0, 1, 32'h703, 1, 0));
    vecs.push_back(mk("t6_gap",    1, 0, 32'h0,   1, 32'h800, 0,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk("t6_ownd",   1, 0, 32'h0,   1, 32'h800, 0,   0, 1, 1, 32'h800, 0, 0));
    // reset mid D-burst after two beats, then a fresh 4-beat burst
    vecs.push_back(mk("t1_d1",     1, 0, 32'h0,   1, 32'h800, 1,   0, 1, 1, 32'h800, 0, 1));
    vecs.push_back(mk("t1_d2",     1, 0, 32'h0,   1, 32'h801, 1,   0, 1, 1, 32'h801, 0, 1));
    vecs.push_back(mk("t1_rst",    0, 0, 32'h0,   1, 32'h802, 1,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk("t1_rst2",   0, 0, 32'h0,   1, 32'h802, 0,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk("t1_idle",   1, 0, 32'h0,   1, 32'h900, 0,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk("t1_n1",     1, 0, 32'h0,   1, 32'h900, 1,   0, 1, 1, 32'h900, 0, 1));
    vecs.push_back(mk("t1_n2",     1, 0, 32'h0,   1, 32'h901, 1,   0, 1, 1, 32'h901, 0, 1));
    vecs.push_back(mk("t1_n3",     1, 0, 32'h0,   1, 32'h902, 1,   0, 1, 1, 32'h902, 0, 1));
    vecs.push_back(mk("t1_n4",     1, 0, 32'h0,   1, 32'h903, 1,   0, 1, 1, 32'h903, 0, 1));
    vecs.push_back(mk("t1_rel",    1, 0, 32'h0,   0, 32'h0,   0,   0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk("end_idle",  1, 0, 32'h0,   0, 32'h0,   0,   0, 0, 0, 32'h0,   0, 0));

    foreach (vecs[k]) apply(vecs[k]);

    // both sides held across three bursts, starting from a fresh reset
`ifdef ARB_RR_EN
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
`else
    exp_order[0] = 2'b01; exp_order[1] = 2'b01; exp_order[2] = 2'b01;
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'hA00;
    d_req = 1'b1; d_addr = 32'hB00;
    mem_ack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      own_q.push_back(exp_order[b]);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(grant_i || grant_d) && n < 8);
      eo = own_q.pop_front();
      ea = eo[1] ? 32'hA00 : 32'hB00;
      checks++;
      if ({grant_i, grant_d} !== eo || mem_addr !== ea) begin
        errors++;
        $display("FAIL burst%0d_owner: got gi/gd=%b%b addr=%h after %0d cycles, exp %b addr=%h",
                 b, grant_i, grant_d, mem_addr, n, eo, ea);
      end
      for (int k = 0; k < 4; k++) begin
        mem_ack = 1'b1;
        #1;
        checks++;
        if ({i_ack, d_ack} !== eo) begin
          errors++;
          $display("FAIL burst%0d_ack%0d: got iack/dack=%b%b, exp %b", b, k, i_ack, d_ack, eo);
        end
        @(negedge clk);
      end
      mem_ack = 1'b0;
      #1;
      checks++;
      if ({grant_i, grant_d} !== 2'b00) begin
        errors++;
        $display("FAIL burst%0d_gap: got gi/gd=%b%b, exp 00", b, grant_i, grant_d);
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
